// File: rtl/fu_result_buffer.sv
// rtl/fu_result_buffer.sv - per-FU completion queue feeding one CDB arbiter slot, with starvation flag
// Optional RESULT_BUF_BYPASS_EN: empty-buffer results reach out_valid/out_data in the same cycle.
module fu_result_buffer #(
    parameter int  DATA_W       = 32,  // $bits(cdb_entry_t)
    parameter int  DEPTH        = 4,
    parameter int  STARVE_LIMIT = 16,
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              cdb_grant,
    output logic [CNT_W-1:0]  count,
    output logic              starve
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [WAIT_W-1:0] r_wait_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full;
    assign w_pop    = !w_empty && cdb_grant;
    assign count    = r_count;
    assign starve   = (r_wait_cnt == WAIT_W'(STARVE_LIMIT));

`ifdef RESULT_BUF_BYPASS_EN
    // A result granted straight through while empty never enters storage.
    assign w_push    = in_valid && !w_full && !(w_empty && cdb_grant);
    assign out_valid = !w_empty || in_valid;
    assign out_data  = !w_empty ? r_mem[r_rd_ptr] : (in_valid ? in_data : '0);
`else
    assign w_push    = in_valid && !w_full;
    assign out_valid = !w_empty;
    assign out_data  = !w_empty ? r_mem[r_rd_ptr] : '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wait_cnt <= '0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop || w_empty)
                r_wait_cnt <= '0;
            else if (r_wait_cnt != WAIT_W'(STARVE_LIMIT))
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (rst && !flush && w_push)
            r_mem[r_wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            assert (!(w_push && w_full)) else $error("push while full");
            assert (!(w_pop && w_empty)) else $error("pop while empty");
            assert (PTR_W'(r_wr_ptr - r_rd_ptr) == r_count[PTR_W-1:0])
                else $error("count does not match pointer distance");
        end
    end

endmodule

// File: tb/tb_fu_result_buffer.sv
// tb/tb_fu_result_buffer.sv - scoreboard bench for fu_result_buffer
module tb_fu_result_buffer;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              cdb_grant;
    logic [CNT_W-1:0]  count;
    logic              starve;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] sb [$];

    fu_result_buffer #(.DATA_W(DATA_W), .DEPTH(4), .STARVE_LIMIT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .cdb_grant (cdb_grant),
        .count     (count),
        .starve    (starve)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        sb.push_back(d);
        cyc();
        in_valid = 1'b0;
    endtask

    // Monitor: every accepted pop is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (rst && !flush && out_valid && cdb_grant) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %0h expected none", out_data);
            end else begin
                check("pop_data", out_data, sb.pop_front());
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; cdb_grant = 1'b0;
        repeat (3) cyc();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_starve",    32'(starve),    32'd0);
        check("rst_out_data",  out_data,       32'd0);
        rst = 1'b1; in_valid = 1'b0;
        cyc();
        check("post_rst_count", 32'(count), 32'd0);

        // Fill and order; E offered while full must be dropped
        push_one(32'hA);
        check("first_latency_valid", 32'(out_valid), 32'd1);
        push_one(32'hB);
        push_one(32'hC);
        push_one(32'hD);
        check("full_count",    32'(count),    32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_data = 32'hE;
        cyc();
        in_valid = 1'b0;
        check("drop_e_count", 32'(count), 32'd4);
        cdb_grant = 1'b1;
        repeat (4) cyc();
        cdb_grant = 1'b0;
        check("drain_count", 32'(count),     32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);

        // Grant while empty is ignored
        cdb_grant = 1'b1;
        cyc();
        cdb_grant = 1'b0;
        check("idle_grant_count", 32'(count), 32'd0);

        // Simultaneous push and pop at count=2
        push_one(32'h11);
        push_one(32'h22);
        in_valid = 1'b1; in_data = 32'h33; cdb_grant = 1'b1;
        sb.push_back(32'h33);
        cyc();
        in_valid = 1'b0;
        check("simul_count", 32'(count), 32'd2);
        repeat (2) cyc();
        cdb_grant = 1'b0;
        check("simul_drain_count", 32'(count), 32'd0);

        // Starvation threshold and saturation
        push_one(32'h55);
        repeat (15) cyc();
        check("starve_before_limit", 32'(starve), 32'd0);
        cyc();
        check("starve_at_limit", 32'(starve), 32'd1);
        cyc();
        check("starve_saturated", 32'(starve), 32'd1);
        cdb_grant = 1'b1;
        cyc();
        cdb_grant = 1'b0;
        check("starve_cleared", 32'(starve), 32'd0);
        check("starve_pop_count", 32'(count), 32'd0);

        // Flush discards stored entries and same-cycle push/pop
        push_one(32'h61);
        push_one(32'h62);
        push_one(32'h63);
        check("pre_flush_count", 32'(count), 32'd3);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h64; cdb_grant = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0; cdb_grant = 1'b0;
        sb.delete();
        check("flush_count",  32'(count),     32'd0);
        check("flush_valid",  32'(out_valid), 32'd0);
        check("flush_starve", 32'(starve),    32'd0);

        // Full with pop in the same cycle: push still refused
        push_one(32'h70);
        push_one(32'h71);
        push_one(32'h72);
        push_one(32'h73);
        in_valid = 1'b1; in_data = 32'h74; cdb_grant = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("full_pop_count", 32'(count), 32'd3);
        repeat (3) cyc();
        cdb_grant = 1'b0;
        check("full_pop_drain", 32'(count), 32'd0);

        // Empty buffer, result offered together with a grant
        in_valid = 1'b1; in_data = 32'h5A; cdb_grant = 1'b1;
        sb.push_back(32'h5A);
        #1;
`ifdef RESULT_BUF_BYPASS_EN
        check("bypass_valid", 32'(out_valid), 32'd1);
        check("bypass_data",  out_data,       32'h5A);
        cyc();
        in_valid = 1'b0; cdb_grant = 1'b0;
        check("bypass_count", 32'(count), 32'd0);
`else
        check("nobypass_valid", 32'(out_valid), 32'd0);
        cyc();
        in_valid = 1'b0; cdb_grant = 1'b0;
        check("nobypass_next_valid", 32'(out_valid), 32'd1);
        check("nobypass_next_data",  out_data,       32'h5A);
        check("nobypass_count",      32'(count),     32'd1);
        cdb_grant = 1'b1;
        cyc();
        cdb_grant = 1'b0;
        check("nobypass_drain", 32'(count), 32'd0);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
